// File: rtl/key_ctrl_pkg.sv
// Shared state encoding and default debounce length for the stopwatch key controller.
package key_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam int DB_CYCLES_DEFAULT = 1_000_000;

endpackage

// File: rtl/key_debounce.sv
// One raw active-low key -> synchronized, debounced, one-cycle press pulse.
// Latency: press pulse DB_CYCLES+3 edges after the first low sample; no backpressure.
module key_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DB_CYCLES);

    logic          sync1;
    logic          sync2;
    logic          acc;
    logic          acc_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    // Counter only runs while the synced level disagrees; it tops out at DB_CYCLES-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            acc <= 1'b1;
        end else if (sync2 != acc) begin
            if (cnt == CW'(DB_CYCLES - 1)) begin
                acc <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_d <= 1'b1;
            press <= 1'b0;
        end else begin
            acc_d <= acc;
            press <= acc_d & ~acc;
        end
    end

endmodule

// File: rtl/key_ctrl.sv
// Stopwatch control: three debounced keys drive an IDLE/RUN/PAUSE FSM with lap hold.
// Latency: outputs update one edge after a press event; no backpressure.
module key_ctrl
    import key_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_start_n,
    input  logic       key_clr_n,
    input  logic       key_lap_n,
    output logic       run_en,
    output logic       clr_pulse,
    output logic       hold,
    output logic [1:0] state
);

    logic start_ev;
    logic clr_ev;
    logic lap_ev;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_start_n),
        .press (start_ev)
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_clr_n),
        .press (clr_ev)
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_lap_n),
        .press (lap_ev)
    );

    logic [1:0] state_d;
    logic       hold_d;
    logic       clr_d;

    always_comb begin
        state_d = state;
        hold_d  = hold;
        clr_d   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (clr_ev) begin
                    clr_d = 1'b1;
                end else if (start_ev) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (start_ev) begin
                    state_d = ST_PAUSE;
                end
                if (lap_ev) begin
                    hold_d = ~hold;
                end
            end
            ST_PAUSE: begin
                if (clr_ev) begin
                    state_d = ST_IDLE;
                    clr_d   = 1'b1;
                    hold_d  = 1'b0;
                end else begin
                    if (start_ev) begin
                        state_d = ST_RUN;
                    end
                    if (lap_ev) begin
                        hold_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = 1'b0;
            end
        endcase
        // Guarantees the counter clear can never stretch over two cycles.
        if (clr_pulse) begin
            clr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            hold      <= 1'b0;
            clr_pulse <= 1'b0;
            run_en    <= 1'b0;
        end else begin
            state     <= state_d;
            hold      <= hold_d;
            clr_pulse <= clr_d;
            run_en    <= (state_d == ST_RUN);
        end
    end

endmodule

// File: tb/tb_key_ctrl.sv
// Self-checking bench for key_ctrl with DB_CYCLES=16: per-cycle reference model plus directed tables.
module tb_key_ctrl;

    localparam int DB   = 16;
    localparam int MAXC = 8192;

    logic       clk;
    logic       rst_n;
    logic       key_start_n;
    logic       key_clr_n;
    logic       key_lap_n;
    logic       run_en;
    logic       clr_pulse;
    logic       hold;
    logic [1:0] state;

    key_ctrl #(.DB_CYCLES(DB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_start_n (key_start_n),
        .key_clr_n   (key_clr_n),
        .key_lap_n   (key_lap_n),
        .run_en      (run_en),
        .clr_pulse   (clr_pulse),
        .hold        (hold),
        .state       (state)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: keys indexed 0=start, 1=clr, 2=lap.
    int       t = 0;
    bit [2:0] m_s1, m_s2, m_acc, m_fl, m_ev;
    int       last_flip [3];
    bit       hist [3][MAXC];
    int       m_state = 0;
    bit       m_hold  = 1'b0;
    bit       m_clr   = 1'b0;
    logic     prev_clr = 1'b0;
    int       clr_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, t);
        end
    endtask

    // A level is accepted once the synchronized input has disagreed with it for
    // DB consecutive samples, all taken after the previous acceptance or reset.
    task automatic model_edge();
        bit [2:0] raw;
        raw = {key_lap_n, key_clr_n, key_start_n};
        t++;
        if (!rst_n) begin
            m_s1 = '1; m_s2 = '1; m_acc = '1; m_fl = '0; m_ev = '0;
            for (int k = 0; k < 3; k++) last_flip[k] = t;
            m_state = 0; m_hold = 1'b0; m_clr = 1'b0;
            return;
        end
        m_clr = 1'b0;
        case (m_state)
            0: if (m_ev[1]) m_clr = 1'b1; else if (m_ev[0]) m_state = 1;
            1: begin
                if (m_ev[0]) m_state = 2;
                if (m_ev[2]) m_hold = !m_hold;
            end
            default: begin
                if (m_ev[1]) begin
                    m_state = 0; m_clr = 1'b1; m_hold = 1'b0;
                end else begin
                    if (m_ev[0]) m_state = 1;
                    if (m_ev[2]) m_hold = 1'b0;
                end
            end
        endcase
        m_ev = m_fl;
        for (int k = 0; k < 3; k++) begin
            bit ok;
            hist[k][t % MAXC] = m_s2[k];
            ok = 1'b1;
            for (int j = 0; j < DB; j++) begin
                if ((t - j) <= last_flip[k] || hist[k][(t - j) % MAXC] == m_acc[k]) ok = 1'b0;
            end
            m_fl[k] = ok && m_acc[k];
            if (ok) begin
                m_acc[k]     = !m_acc[k];
                last_flip[k] = t;
            end
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("state", state, m_state);
        chk("run_en", run_en, (m_state == 1));
        chk("hold", hold, m_hold);
        chk("clr_pulse", clr_pulse, m_clr);
        if (clr_pulse === 1'b1) begin
            chk("clr_consecutive", prev_clr, 0);
            clr_seen++;
        end
        prev_clr = clr_pulse;
    endtask

    task automatic set_keys(input bit [2:0] pressed);
        key_start_n = !pressed[0];
        key_clr_n   = !pressed[1];
        key_lap_n   = !pressed[2];
    endtask

    task automatic press(input bit [2:0] mask);
        set_keys(mask);
        repeat (DB + 10) tick();
        set_keys(3'b000);
        repeat (DB + 10) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit [2:0] keys;
        int       st;
        bit       hl;
        int       clrs;
    } vec_t;

    vec_t tbl [22];

    initial begin
        int t_low;
        int t_chg;
        int n_chg;
        logic [1:0] last_st;

        tbl[0]  = '{3'b001, 1, 1'b0, 0};
        tbl[1]  = '{3'b001, 2, 1'b0, 0};
        tbl[2]  = '{3'b001, 1, 1'b0, 0};
        tbl[3]  = '{3'b010, 1, 1'b0, 0};
        tbl[4]  = '{3'b001, 2, 1'b0, 0};
        tbl[5]  = '{3'b010, 0, 1'b0, 1};
        tbl[6]  = '{3'b001, 1, 1'b0, 0};
        tbl[7]  = '{3'b100, 1, 1'b1, 0};
        tbl[8]  = '{3'b100, 1, 1'b0, 0};
        tbl[9]  = '{3'b100, 1, 1'b1, 0};
        tbl[10] = '{3'b001, 2, 1'b1, 0};
        tbl[11] = '{3'b010, 0, 1'b0, 1};
        tbl[12] = '{3'b010, 0, 1'b0, 1};
        tbl[13] = '{3'b100, 0, 1'b0, 0};
        tbl[14] = '{3'b001, 1, 1'b0, 0};
        tbl[15] = '{3'b101, 2, 1'b1, 0};
        tbl[16] = '{3'b100, 2, 1'b0, 0};
        tbl[17] = '{3'b011, 0, 1'b0, 1};
        tbl[18] = '{3'b011, 0, 1'b0, 1};
        tbl[19] = '{3'b001, 1, 1'b0, 0};
        tbl[20] = '{3'b011, 2, 1'b0, 0};
        tbl[21] = '{3'b111, 0, 1'b0, 1};

        // Reset with every key held down.
        rst_n = 1'b0;
        set_keys(3'b111);
        repeat (4) tick();
        chk("rst_state", state, 0);
        chk("rst_run_en", run_en, 0);
        chk("rst_hold", hold, 0);
        chk("rst_clr", clr_pulse, 0);
        set_keys(3'b000);
        rst_n = 1'b1;
        repeat (40) tick();
        chk("no_event_after_reset", state, 0);

        // Bouncing start key, then a stable press.
        for (int i = 0; i < 40; i++) begin
            key_start_n = ((i / 5) % 2) != 0;
            tick();
        end
        key_start_n = 1'b0;
        t_low = t + 1;
        t_chg = -1;
        n_chg = 0;
        last_st = state;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (state !== last_st) begin
                n_chg++;
                if (t_chg < 0) t_chg = t;
            end
            last_st = state;
        end
        chk("bounce_transitions", n_chg, 1);
        // The sampling edge counts as the first of the DB+4 edges.
        chk("bounce_latency", t_chg - t_low + 1, DB + 4);
        chk("bounce_run_en", run_en, 1);
        key_start_n = 1'b1;
        repeat (DB + 10) tick();
        chk("bounce_release_no_event", state, 1);

        do_reset();
        for (int i = 0; i < 22; i++) begin
            clr_seen = 0;
            press(tbl[i].keys);
            chk($sformatf("vec%0d_state", i), state, tbl[i].st);
            chk($sformatf("vec%0d_run_en", i), run_en, (tbl[i].st == 1));
            chk($sformatf("vec%0d_hold", i), hold, tbl[i].hl);
            chk($sformatf("vec%0d_clr_count", i), clr_seen, tbl[i].clrs);
        end

        // Reset at debounce count 10, key released during reset.
        do_reset();
        key_start_n = 1'b0;
        repeat (12) tick();
        rst_n = 1'b0;
        key_start_n = 1'b1;
        tick();
        rst_n = 1'b1;
        repeat (40) tick();
        chk("mid_reset_no_event", state, 0);

        // Same, but key stays low through reset: needs a full fresh debounce.
        key_start_n = 1'b0;
        repeat (12) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (DB) tick();
        chk("mid_reset_held_not_yet", state, 0);
        repeat (20) tick();
        chk("mid_reset_held_accepts", state, 1);
        key_start_n = 1'b1;
        repeat (DB + 10) tick();

        // Random key activity with occasional resets against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) key_start_n = !key_start_n;
            if ($urandom_range(0, 29) == 0) key_clr_n   = !key_clr_n;
            if ($urandom_range(0, 29) == 0) key_lap_n   = !key_lap_n;
            rst_n = ($urandom_range(0, 1499) != 0);
            tick();
        end
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
